load_store_unit: RTL and testbench

- MEM-stage load/store unit between the pipeline's MEM stage and the data-memory bus.
- Converts (funct3, address, data) requests into word-aligned bus transactions with byte enables and lane-replicated store data.
- Extracts and sign/zero-extends load data.
- Decodes the LED MMIO register.
- Stalls the pipeline while a bus transaction is outstanding.

---
 rtl/load_store_unit_if.sv | 38 +++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for the load/store unit.
// master: the load/store unit side; slave: the pipeline + memory side.
interface load_store_unit_if #(
    parameter int XLEN = 32,
    parameter int ALEN = 32
);
    logic            req_valid;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [ALEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            stall;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            fault;
    logic            bus_req;
    logic            bus_we;
    logic [ALEN-1:0] bus_addr;
    logic [3:0]      bus_be;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [XLEN-1:0] bus_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output stall, resp_valid, resp_rdata, fault,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  stall, resp_valid, resp_rdata, fault,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns funct3/address/data requests into
// word-aligned bus transactions, extracts load data, owns the LED MMIO
// register and stalls the pipeline while a transaction is in flight.
module load_store_unit #(
    parameter int              XLEN          = 32,
    parameter int              ALEN          = 32,
    parameter int              LED_WIDTH     = 4,
    parameter logic [ALEN-1:0] MMIO_LED_ADDR = 32'hFFFF_FFF0
) (
    input  logic                 clk,
    input  logic                 rst,
    load_store_unit_if.master    lsu,
    output logic [LED_WIDTH-1:0] led_out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t     state;
    logic [2:0] lat_funct3;
    logic [1:0] lat_lo;

    // Illegal funct3 for the direction, or address not aligned to the access size.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic illegal;
        logic misaligned;
        illegal    = we ? (f3 > 3'b010) : (f3 == 3'b011 || f3[2:1] == 2'b11);
        misaligned = (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
        return illegal || misaligned;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store data across every lane it may land on.
    function automatic logic [XLEN-1:0] lane_replicate(input logic [2:0] f3, input logic [XLEN-1:0] w);
        case (f3[1:0])
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Pick the addressed byte/half out of the bus word and extend it.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                     input logic [XLEN-1:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return XLEN'(b);
            3'b001:  return XLEN'(h);
            3'b100:  return XLEN'($unsigned(b));
            3'b101:  return XLEN'($unsigned(h));
            default: return word;
        endcase
    endfunction

    // Pipeline hold: the incoming request while idle, always while the bus is busy.
    always_comb begin
        lsu.stall = 1'b0;
        case (state)
            IDLE:      lsu.stall = lsu.req_valid;
            REQ, WAIT: lsu.stall = 1'b1;
            default:   lsu.stall = 1'b0;
        endcase
    end

    // Transaction FSM with registered bus, response and LED outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            led_out        <= '0;
            lsu.resp_valid <= 1'b0;
            lsu.resp_rdata <= '0;
            lsu.fault      <= 1'b0;
            lsu.bus_req    <= 1'b0;
            lsu.bus_we     <= 1'b0;
            lsu.bus_addr   <= '0;
            lsu.bus_be     <= '0;
            lsu.bus_wdata  <= '0;
        end else begin
            lsu.resp_valid <= 1'b0;
            lsu.fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu.req_valid) begin
                        lat_funct3 <= lsu.req_funct3;
                        lat_lo     <= lsu.req_addr[1:0];
                        if (req_bad(lsu.req_we, lsu.req_funct3, lsu.req_addr[1:0])) begin
                            state          <= DONE;
                            lsu.resp_valid <= 1'b1;
                            lsu.fault      <= 1'b1;
                            lsu.resp_rdata <= '0;
                        end else if (lsu.req_addr == MMIO_LED_ADDR) begin
                            state          <= DONE;
                            lsu.resp_valid <= 1'b1;
                            if (lsu.req_we) begin
                                led_out        <= lsu.req_wdata[LED_WIDTH-1:0];
                                lsu.resp_rdata <= '0;
                            end else begin
                                lsu.resp_rdata <= XLEN'(led_out);
                            end
                        end else begin
                            state         <= REQ;
                            lsu.bus_req   <= 1'b1;
                            lsu.bus_we    <= lsu.req_we;
                            lsu.bus_addr  <= {lsu.req_addr[ALEN-1:2], 2'b00};
                            lsu.bus_be    <= byte_enable(lsu.req_funct3, lsu.req_addr[1:0]);
                            lsu.bus_wdata <= lane_replicate(lsu.req_funct3, lsu.req_wdata);
                        end
                    end
                end
                REQ: begin
                    // rvalid in the grant cycle is not ours; only gnt is looked at here.
                    if (lsu.bus_gnt) begin
                        lsu.bus_req <= 1'b0;
                        if (lsu.bus_we) begin
                            state          <= DONE;
                            lsu.resp_valid <= 1'b1;
                            lsu.resp_rdata <= '0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (lsu.bus_rvalid) begin
                        state          <= DONE;
                        lsu.resp_valid <= 1'b1;
                        lsu.resp_rdata <= load_extract(lat_funct3, lat_lo, lsu.bus_rdata);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, reset-in-flight
// sequence, then randomized requests against a behavioural model.
module tb_load_store_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] led_out;

    load_store_unit_if #(.XLEN(32), .ALEN(32)) bus_if ();

    load_store_unit dut (
        .clk     (clk),
        .rst     (rst),
        .lsu     (bus_if),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          gd;
        int          rd;
        logic        junk;
        logic        fault;
        logic        on_bus;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [3:0]  led;
        int          lat;
    } vec_t;

    typedef struct {
        logic        fault;
        logic        on_bus;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [3:0]  led;
    } exp_t;

    vec_t vecs[14];

    // Observations from the most recent transaction.
    int          got_lat, got_stall, got_breq;
    logic        got_unstable, got_fault, got_extra, got_done;
    logic [31:0] got_rdata, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, want);
        end
    endtask

    // Behavioural reference: sizes, offsets and extension by plain arithmetic.
    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] word,
                                   input logic [3:0] led_now);
        exp_t        e;
        int unsigned size, off;
        logic [31:0] mask, v;
        logic        illegal, mmio;
        size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off     = addr % 4;
        mask    = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        e.fault = illegal || ((off % size) != 0);
        mmio    = (addr == 32'hFFFF_FFF0);
        e.on_bus = !e.fault && !mmio;
        e.baddr  = addr - off;
        e.be     = 4'(((1 << size) - 1) << off);
        e.bwdata = (size == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
                   (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
        v = (word >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && v > (mask >> 1)) v = v - (mask + 32'd1);
        if (e.fault || we) e.rdata = 32'h0;
        else if (mmio)     e.rdata = {28'h0, led_now};
        else               e.rdata = v;
        e.led = (!e.fault && mmio && we) ? wdata[3:0] : led_now;
        return e;
    endfunction

    function automatic int exp_latency(input exp_t e, input logic we, input int gd, input int rd);
        if (!e.on_bus) return 1;
        return we ? 2 + gd : 2 + gd + rd;
    endfunction

    // Issue one request (starting just after a posedge) and play the memory side.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word,
                           input int gd, input int rd, input logic junk);
        int   req_seen, gnt_cycle;
        logic granted, rv_done;
        got_lat = -1; got_stall = 0; got_breq = 0; got_unstable = 0;
        got_fault = 0; got_rdata = 0; got_done = 0; got_extra = 0;
        cap_addr = 0; cap_wdata = 0; cap_be = 0; cap_we = 0;
        req_seen = 0; gnt_cycle = 0; granted = 0; rv_done = 0;
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = we;
        bus_if.req_funct3 = f3;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wdata;
        for (int k = 0; k < 60 && !got_done; k++) begin
            bus_if.bus_gnt    = 1'b0;
            bus_if.bus_rvalid = 1'b0;
            bus_if.bus_rdata  = $urandom;
            if (bus_if.bus_req && !granted) begin
                if (req_seen == gd) begin
                    bus_if.bus_gnt = 1'b1;
                    granted   = 1'b1;
                    gnt_cycle = k;
                    if (junk) begin
                        bus_if.bus_rvalid = 1'b1;
                        bus_if.bus_rdata  = ~word;
                    end
                end
                req_seen++;
            end else if (granted && !rv_done && !we && k == gnt_cycle + rd) begin
                bus_if.bus_rvalid = 1'b1;
                bus_if.bus_rdata  = word;
                rv_done = 1'b1;
            end
            @(negedge clk);
            if (bus_if.stall) got_stall++;
            if (bus_if.bus_req) begin
                if (got_breq == 0) begin
                    cap_addr  = bus_if.bus_addr;
                    cap_wdata = bus_if.bus_wdata;
                    cap_be    = bus_if.bus_be;
                    cap_we    = bus_if.bus_we;
                end else if (cap_addr !== bus_if.bus_addr || cap_wdata !== bus_if.bus_wdata ||
                             cap_be !== bus_if.bus_be || cap_we !== bus_if.bus_we) begin
                    got_unstable = 1'b1;
                end
                got_breq++;
            end
            if (bus_if.resp_valid) begin
                got_done  = 1'b1;
                got_lat   = k;
                got_rdata = bus_if.resp_rdata;
                got_fault = bus_if.fault;
            end
            @(posedge clk); #1;
        end
        bus_if.req_valid  = 1'b0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        @(negedge clk);
        got_extra = bus_if.resp_valid;
        @(posedge clk); #1;
    endtask

    task automatic check_txn(input string tag, input exp_t e, input int lat, input int gd, input logic we);
        check({tag, "_done"}, got_done, 1'b1);
        check({tag, "_lat"}, got_lat, lat);
        check({tag, "_stall"}, got_stall, lat);
        check({tag, "_fault"}, got_fault, e.fault);
        check({tag, "_rdata"}, got_rdata, e.rdata);
        check({tag, "_pulse"}, got_extra, 1'b0);
        check({tag, "_led"}, led_out, e.led);
        check({tag, "_breq"}, got_breq, e.on_bus ? gd + 1 : 0);
        if (e.on_bus) begin
            check({tag, "_baddr"}, cap_addr, e.baddr);
            check({tag, "_be"}, cap_be, e.be);
            check({tag, "_bwdata"}, cap_wdata, e.bwdata);
            check({tag, "_bwe"}, cap_we, we);
            check({tag, "_stable"}, got_unstable, 1'b0);
        end
    endtask

    initial begin
        exp_t        e;
        logic [3:0]  exp_led;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          gd, rd, r;

        //          we f3     addr          wdata         word          gd rd jk flt bus baddr         bwdata        rdata         be       led   lat
        vecs[0]  = '{1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0,        0, 1, 0, 0, 1, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0,        4'b1000, 4'h0, 2};
        vecs[1]  = '{0, 3'd0, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 0, 1, 0, 0, 1, 32'h0000_0100, 32'h0,        32'hFFFF_FFFF, 4'b0100, 4'h0, 3};
        vecs[2]  = '{0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 0, 1, 0, 0, 1, 32'h0000_0100, 32'h0,        32'h0000_0080, 4'b1000, 4'h0, 3};
        vecs[3]  = '{0, 3'd1, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 0, 1, 0, 0, 1, 32'h0000_0100, 32'h0,        32'hFFFF_80FF, 4'b1100, 4'h0, 3};
        vecs[4]  = '{0, 3'd5, 32'h0000_0100, 32'h0,        32'h80FF_7F01, 0, 1, 0, 0, 1, 32'h0000_0100, 32'h0,        32'h0000_7F01, 4'b0011, 4'h0, 3};
        vecs[5]  = '{0, 3'd2, 32'h0000_0102, 32'h0,        32'h0,        0, 1, 0, 1, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 4'h0, 1};
        vecs[6]  = '{1, 3'd2, 32'hFFFF_FFF0, 32'h0000_000B, 32'h0,        0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 4'hB, 1};
        vecs[7]  = '{0, 3'd2, 32'hFFFF_FFF0, 32'h0,        32'h0,        0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0000_000B, 4'b0000, 4'hB, 1};
        vecs[8]  = '{0, 3'd2, 32'h0000_0200, 32'h0,        32'h1234_5678, 5, 3, 0, 0, 1, 32'h0000_0200, 32'h0,        32'h1234_5678, 4'b1111, 4'hB, 10};
        vecs[9]  = '{1, 3'd1, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        0, 1, 0, 0, 1, 32'h0000_0100, 32'hABCD_ABCD, 32'h0,        4'b1100, 4'hB, 2};
        vecs[10] = '{1, 3'd4, 32'h0000_0100, 32'h0,        32'h0,        0, 1, 0, 1, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 4'hB, 1};
        vecs[11] = '{0, 3'd3, 32'h0000_0100, 32'h0,        32'h0,        0, 1, 0, 1, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 4'hB, 1};
        vecs[12] = '{0, 3'd2, 32'h0000_0104, 32'h0,        32'hCAFE_F00D, 0, 1, 1, 0, 1, 32'h0000_0104, 32'h0,        32'hCAFE_F00D, 4'b1111, 4'hB, 3};
        vecs[13] = '{0, 3'd0, 32'h0000_0101, 32'h0,        32'h0000_8000, 2, 2, 0, 0, 1, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 4'b0010, 4'hB, 6};

        rst = 1'b1;
        bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_funct3 = 3'd0;
        bus_if.req_addr = 32'h0; bus_if.req_wdata = 32'h0;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_bus_req", bus_if.bus_req, 1'b0);
        check("rst_resp_valid", bus_if.resp_valid, 1'b0);
        check("rst_fault", bus_if.fault, 1'b0);
        check("rst_resp_rdata", bus_if.resp_rdata, 32'h0);
        check("rst_led", led_out, 4'h0);
        check("rst_bus_addr", bus_if.bus_addr, 32'h0);
        check("rst_bus_be", bus_if.bus_be, 4'h0);
        check("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
        check("rst_stall", bus_if.stall, 1'b0);
        @(posedge clk); #1;

        // Directed vectors with hand-derived expectations.
        for (int i = 0; i < 14; i++) begin
            e.fault = vecs[i].fault; e.on_bus = vecs[i].on_bus; e.baddr = vecs[i].baddr;
            e.bwdata = vecs[i].bwdata; e.rdata = vecs[i].rdata; e.be = vecs[i].be; e.led = vecs[i].led;
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].word,
                    vecs[i].gd, vecs[i].rd, vecs[i].junk);
            check_txn($sformatf("vec%0d", i), e, vecs[i].lat, vecs[i].gd, vecs[i].we);
        end

        // Reset while a load waits for read data: the late rvalid must be dropped.
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b0; bus_if.req_funct3 = 3'd2;
        bus_if.req_addr = 32'h0000_0100; bus_if.req_wdata = 32'h0;
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        check("rw_bus_req", bus_if.bus_req, 1'b1);
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b0; bus_if.req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rw_wait_stall", bus_if.stall, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
        @(negedge clk);
        check("rw_resp_valid", bus_if.resp_valid, 1'b0);
        check("rw_bus_req_low", bus_if.bus_req, 1'b0);
        check("rw_stall_idle", bus_if.stall, 1'b0);
        check("rw_led", led_out, 4'h0);
        @(posedge clk); #1;
        bus_if.bus_rvalid = 1'b0;
        @(negedge clk);
        check("rw_resp_valid_late", bus_if.resp_valid, 1'b0);
        check("rw_resp_rdata", bus_if.resp_rdata, 32'h0);
        @(posedge clk); #1;
        exp_led = 4'h0;

        // Randomized requests against the model.
        for (int n = 0; n < 250; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r == 0)      addr = 32'hFFFF_FFF0;
            else if (r == 1) addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 3));
            else             addr = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
            gd = $urandom_range(0, 3);
            rd = $urandom_range(1, 3);
            begin
                logic [31:0] wd, wo;
                logic        jk;
                wd = $urandom; wo = $urandom; jk = 1'($urandom_range(0, 1));
                e = model(we, f3, addr, wd, wo, exp_led);
                run_txn(we, f3, addr, wd, wo, gd, rd, jk);
                check_txn($sformatf("rnd%0d", n), e, exp_latency(e, we, gd, rd), gd, we);
                exp_led = e.led;
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
